// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for mem_port_arbiter: the FSM state encoding, the NOP
// instruction returned on reset or on an aborted fetch, and the full-word
// byte mask used on every read.
// ---------------------------------------------------------------------------
package arb_pkg;

  // One pipeline step walks ARB -> [D_ACC] -> I_ACC -> REL -> ARB.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    REL   = 2'd3
  } arb_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [3:0]  MASK_ALL = 4'hF;

endpackage : arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Single req/ack memory bus shared by fetch and data access.
//   master : the arbiter (drives req/we/adr/wdata/mask/err)
//   slave  : the memory  (drives ack/rdata)
// bus_ack is a single-cycle pulse; bus_rdata is valid alongside it.
// bus_err pulses when the arbiter abandons an access (watchdog builds only).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_adr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_mask;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_adr, bus_wdata, bus_mask, bus_err,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_adr, bus_wdata, bus_mask, bus_err,
    output bus_ack, bus_rdata
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_watchdog.sv
// ---------------------------------------------------------------------------
// arb_watchdog
// Counts consecutive un-acked cycles of a bus access and flags a timeout on
// the TIMEOUT-th such cycle. Only built when ARB_WATCHDOG_EN is defined.
//   clk, rst  : clock, asynchronous active-low reset
//   active    : an access is being presented on the bus this cycle
//   ack       : bus completion this cycle
//   timeout   : combinational abort request for the current cycle
// The counter returns to zero whenever no access is active and whenever an
// access completes (ack or timeout), so every access starts counting at 0.
// ---------------------------------------------------------------------------
`ifdef ARB_WATCHDOG_EN
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic timeout
);

  // The count never exceeds TIMEOUT-1, so TIMEOUT=255 gives an 8-bit counter.
  localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = active && !ack && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!active || ack || timeout) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : arb_watchdog
`endif

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one external req/ack memory port between instruction fetch and the
// MEM-stage data access. Each pipeline step is serialised as data access
// (older instruction) first, then fetch; `stall` holds the pipeline until
// both have completed and drops for exactly one cycle (REL) to advance it.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   if_adr            fetch address (PC)
//   inst              fetched instruction, registered (NOP after reset)
//   d_rd, d_wr        load / store request (both set = store)
//   d_adr, d_wdata    data address / store data
//   d_mask            store byte mask
//   d_rdata           load data, registered
//   stall             1 = freeze all pipeline enables
//   bus               mem_port_arbiter_if.master, all bus outputs registered
//
// Optional feature: define ARB_WATCHDOG_EN to abort any access left un-acked
// for TIMEOUT cycles; the captured value becomes 0 (NOP for a fetch),
// bus_err pulses once and the step continues as if ack had arrived. Without
// it the arbiter waits indefinitely and bus_err is tied low.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_adr,
  output logic [DATA_W-1:0] inst,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_mask,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  mem_port_arbiter_if.master bus
);

  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INST);

  arb_state_e        state_q, state_d;
  // Only the fetch address and the access direction need a snapshot; the
  // data-side address/data/mask are loaded straight into the bus registers
  // on the same ARB edge and held there for the whole data access.
  logic [ADDR_W-1:0] snap_ifadr_q, snap_ifadr_d;
  logic              snap_wr_q, snap_wr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_adr_q, bus_adr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_mask_q, bus_mask_d;

  logic timeout;   // watchdog abort for the current access cycle
  logic acc_done;  // current access finishes this cycle (ack or abort)

`ifdef ARB_WATCHDOG_EN
  logic bus_err_q, bus_err_d;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  ((state_q == D_ACC) || (state_q == I_ACC)),
    .ack     (bus.bus_ack),
    .timeout (timeout)
  );

  assign bus_err_d   = timeout;
  assign bus.bus_err = bus_err_q;
`else
  // TIMEOUT has no role without the watchdog; it is folded into a constant 0.
  assign timeout     = 1'b0 && (TIMEOUT != 0);
  assign bus.bus_err = 1'b0;
`endif

  assign acc_done = bus.bus_ack || timeout;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d signal takes its held value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    snap_ifadr_d = snap_ifadr_q;
    snap_wr_d    = snap_wr_q;
    inst_d       = inst_q;
    d_rdata_d    = d_rdata_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_adr_d    = bus_adr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_mask_d   = bus_mask_q;

    unique case (state_q)
      ARB: begin
        snap_ifadr_d = if_adr;
        snap_wr_d    = d_wr;
        bus_req_d    = 1'b1;
        if (d_rd || d_wr) begin
          // A simultaneous load and store is treated as a store.
          state_d     = D_ACC;
          bus_we_d    = d_wr;
          bus_adr_d   = d_adr;
          bus_wdata_d = d_wr ? d_wdata : '0;
          bus_mask_d  = d_wr ? d_mask  : MASK_ALL;
        end else begin
          state_d     = I_ACC;
          bus_we_d    = 1'b0;
          bus_adr_d   = if_adr;
          bus_wdata_d = '0;
          bus_mask_d  = MASK_ALL;
        end
      end

      D_ACC: begin
        if (acc_done) begin
          if (!snap_wr_q) begin
            d_rdata_d = timeout ? '0 : bus.bus_rdata;
          end
          // Request stays high straight into the fetch with the new address.
          state_d     = I_ACC;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_adr_d   = snap_ifadr_q;
          bus_wdata_d = '0;
          bus_mask_d  = MASK_ALL;
        end
      end

      I_ACC: begin
        if (acc_done) begin
          inst_d      = timeout ? NOP_WORD : bus.bus_rdata;
          state_d     = REL;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_adr_d   = '0;
          bus_wdata_d = '0;
          bus_mask_d  = '0;
        end
      end

      REL: begin
        state_d = ARB;
      end

      default: begin
        state_d = ARB;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      snap_ifadr_q <= '0;
      snap_wr_q    <= 1'b0;
      inst_q       <= NOP_WORD;
      d_rdata_q    <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_adr_q    <= '0;
      bus_wdata_q  <= '0;
      bus_mask_q   <= '0;
    end else begin
      state_q      <= state_d;
      snap_ifadr_q <= snap_ifadr_d;
      snap_wr_q    <= snap_wr_d;
      inst_q       <= inst_d;
      d_rdata_q    <= d_rdata_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_adr_q    <= bus_adr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_mask_q   <= bus_mask_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stall         = (state_q != REL);
  assign inst          = inst_q;
  assign d_rdata       = d_rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_adr   = bus_adr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_mask  = bus_mask_q;

endmodule : mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the pipeline's instruction fetch and its MEM-stage data access.
- Sits between the datapath (fetch address, load/store controls, byte mask) and a single req/ack memory bus.
- Serialises each pipeline step as: data access first (older instruction), then fetch.
- Holds the whole pipeline via `stall` until both accesses for the current step have completed.

Parameters:
- ADDR_W, 32, width of fetch, data and bus addresses
- DATA_W, 32, width of instruction, data and bus data
- TIMEOUT, 255, watchdog limit in cycles; used only with ARB_WATCHDOG_EN

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- if_adr  in  ADDR_W  fetch address (PC)
- inst  out  DATA_W  fetched instruction, registered
- d_rd  in  1  load request from MEM stage
- d_wr  in  1  store request from MEM stage
- d_adr  in  ADDR_W  word-aligned data address
- d_wdata  in  DATA_W  store data
- d_mask  in  4  store byte mask
- d_rdata  out  DATA_W  load data, registered
- stall  out  1  1 = freeze all pipeline enables
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_adr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_mask  out  4  bus byte mask; 4'hF for reads
- bus_ack  in  1  bus completion, single-cycle pulse
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_err  out  1  watchdog abort pulse (ARB_WATCHDOG_EN only)

Behaviour:
- Reset (rst=0, asynchronous) forces these values at once:
  - state=ARB, stall=1, bus_req=0, bus_we=0
  - bus_adr/bus_wdata=0, bus_mask=0
  - inst=32'h00000013 (NOP), d_rdata=0, bus_err=0
- An access in flight at reset is abandoned; bus_req falls without waiting for ack.
- States:
  - ARB: 1 cycle, bus_req=0. Snapshots if_adr, d_adr, d_wdata, d_mask, d_rd, d_wr into internal registers. Next state is D_ACC if (d_rd|d_wr), else I_ACC.
  - D_ACC: bus_req=1, bus_we=snap_wr, bus_adr=snap_dadr. bus_wdata/bus_mask come from the snapshot on a write; mask is 4'hF on a read. Stays until bus_ack. On ack of a read, d_rdata<=bus_rdata. Then goes to I_ACC.
  - I_ACC: bus_req=1, bus_we=0, bus_adr=snap_ifadr, mask 4'hF. On bus_ack, inst<=bus_rdata and goes to REL.
  - REL: bus_req=0, stall=0 for exactly 1 cycle; the pipeline advances on this edge. Then goes to ARB.
- stall=1 in every state except REL.
- Bus outputs are registered and stay stable while bus_req=1 until the ack cycle. bus_req drops on the cycle after ack.
- Latency with zero-wait memory (ack in the first req cycle):
  - fetch-only step: 3 cycles (ARB, I_ACC, REL)
  - load/store step: 4 cycles (ARB, D_ACC, I_ACC, REL)
- Each bus wait cycle adds 1 cycle to the step.
- bus_ack in ARB or REL is ignored.
- d_rd=d_wr=1 at snapshot: treated as a write; d_rdata is unchanged.
- d_rdata and inst hold their value until the next capture.
- Changes to inputs after the ARB snapshot have no effect until the next ARB.

Optional Feature:
- Macro ARB_WATCHDOG_EN.
- Defined:
  - An 8-bit counter (sized by TIMEOUT) clears on entry to D_ACC/I_ACC and counts each cycle without ack.
  - On reaching TIMEOUT the access is aborted: bus_req drops, the captured value becomes 0 (inst becomes the NOP value), and bus_err pulses for 1 cycle.
  - The FSM then continues as if ack had arrived.
- Undefined: no counter; the block waits forever for ack; bus_err is tied to 0.

Decomposition:
- Package arb_pkg holds:
  - the state encoding (ARB, D_ACC, I_ACC, REL; 2 bits)
  - NOP_INST=32'h00000013
  - MASK_ALL=4'hF
- Sub-module arb_watchdog (counter + compare; emits timeout pulse) is instantiated only under ARB_WATCHDOG_EN.

Test Plan:
- Reset release, no data request, if_adr=0x100, ack in same cycle → bus_adr=0x100, inst=ack data, stall low for 1 cycle, 3 cycles per step.
- d_rd=1, d_adr=0x2000, if_adr=0x104 → D_ACC to 0x2000 (mask F, we=0) precedes fetch of 0x104; d_rdata=bus_rdata at the 0x2000 ack.
- d_wr=1, d_adr=0x3000, d_wdata=0xDEADBEEF, d_mask=4'b0011 → bus_we=1 with those values held through 3 wait cycles; step takes 7 cycles.
- Assert rst=0 mid-D_ACC → bus_req=0 and inst=0x00000013 immediately; after release, a fresh ARB cycle occurs.
- ARB_WATCHDOG_EN, TIMEOUT=4, ack never given in I_ACC → after 4 cycles bus_err pulses once, inst=0x00000013, REL follows.
- Spurious bus_ack in REL/ARB → no capture, state flow unchanged.
